// File: rtl/retire_wb_queue_if.sv
// Bundle of the retirement write buffer's producer side (ALU and LS retire),
// its readiness flag, the two register-file write ports and the occupancy.
// master: the pipeline / register file side. slave: the queue itself.
interface retire_wb_queue_if #(
  parameter int PTR_W  = 3,
  parameter int PREG_W = 6
);
  logic              alu_valid;
  logic [PREG_W-1:0] alu_reg;
  logic [31:0]       alu_data;
  logic              ls_valid;
  logic [PREG_W-1:0] ls_reg;
  logic [31:0]       ls_data;
  logic              in_ready;
  logic              do_writeback1_RET;
  logic [PREG_W-1:0] writeRegister1_RET;
  logic [31:0]       writeData1_RET;
  logic              do_writeback1_LS_RET;
  logic [PREG_W-1:0] writeRegister1_LS_RET;
  logic [31:0]       writeData1_LS_RET;
  logic [PTR_W:0]    count;

  modport master (
    output alu_valid, alu_reg, alu_data, ls_valid, ls_reg, ls_data,
    input  in_ready, do_writeback1_RET, writeRegister1_RET, writeData1_RET,
    input  do_writeback1_LS_RET, writeRegister1_LS_RET, writeData1_LS_RET, count
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data, ls_valid, ls_reg, ls_data,
    output in_ready, do_writeback1_RET, writeRegister1_RET, writeData1_RET,
    output do_writeback1_LS_RET, writeRegister1_LS_RET, writeData1_LS_RET, count
  );
endinterface

// File: rtl/retire_wb_queue.sv
// Ordered retirement write buffer in front of the physical register file.
// Up to two results enter per cycle (ALU older than LS) and up to two drain
// per cycle onto the RET (older) and LS (younger) write ports, so program
// order is kept and the newer same-register write always lands last.
// Optional macro RETQ_FWD_EN adds a combinational forwarding lookup
// (fwd_reg / fwd_hit / fwd_data) over queued and staged entries.
module retire_wb_queue #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3,
  parameter int PREG_W = 6
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FREEZE,
  retire_wb_queue_if.slave  bus
`ifdef RETQ_FWD_EN
  ,
  input  logic [PREG_W-1:0] fwd_reg,
  output logic              fwd_hit,
  output logic [31:0]       fwd_data
`endif
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] ACCEPT_MAX = CNT_W'(DEPTH - 2);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  logic [PREG_W-1:0] q_reg  [DEPTH];
  logic [31:0]       q_data [DEPTH];

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  head_p1;
  logic [PTR_W-1:0]  tail_p1;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  n_push;
  logic [CNT_W-1:0]  n_pop;
  logic              alu_push;
  logic              ls_push;

  logic              ret_en;
  logic [PREG_W-1:0] ret_reg;
  logic [31:0]       ret_data;
  logic              ls_en;
  logic [PREG_W-1:0] ls_reg_q;
  logic [31:0]       ls_data_q;

  assign bus.in_ready = (count_q <= ACCEPT_MAX);
  assign alu_push     = bus.alu_valid && bus.in_ready;
  assign ls_push      = bus.ls_valid && bus.in_ready;
  assign head_p1      = head + PTR_ONE;
  assign tail_p1      = tail + PTR_ONE;

  assign bus.count                 = count_q;
  assign bus.do_writeback1_RET     = ret_en;
  assign bus.writeRegister1_RET    = ret_reg;
  assign bus.writeData1_RET        = ret_data;
  assign bus.do_writeback1_LS_RET  = ls_en;
  assign bus.writeRegister1_LS_RET = ls_reg_q;
  assign bus.writeData1_LS_RET     = ls_data_q;

  // Push and pop amounts for this edge; pops look only at pre-push occupancy.
  always_comb begin
    n_push = CNT_W'(alu_push) + CNT_W'(ls_push);
    n_pop  = '0;
    if (!FREEZE) begin
      if (count_q >= CNT_W'(2))
        n_pop = CNT_W'(2);
      else if (count_q == CNT_W'(1))
        n_pop = CNT_W'(1);
    end
  end

  // Entry storage: ALU takes slot tail when both push, LS then goes to tail+1.
  always_ff @(posedge CLK) begin
    if (alu_push) begin
      q_reg[tail]  <= bus.alu_reg;
      q_data[tail] <= bus.alu_data;
    end
    if (ls_push) begin
      if (alu_push) begin
        q_reg[tail_p1]  <= bus.ls_reg;
        q_data[tail_p1] <= bus.ls_data;
      end else begin
        q_reg[tail]  <= bus.ls_reg;
        q_data[tail] <= bus.ls_data;
      end
    end
  end

  // Pointers, occupancy and the one-cycle output stage onto the write ports.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      head      <= '0;
      tail      <= '0;
      count_q   <= '0;
      ret_en    <= 1'b0;
      ret_reg   <= '0;
      ret_data  <= '0;
      ls_en     <= 1'b0;
      ls_reg_q  <= '0;
      ls_data_q <= '0;
    end else begin
      head    <= head + n_pop[PTR_W-1:0];
      tail    <= tail + n_push[PTR_W-1:0];
      count_q <= count_q + n_push - n_pop;
      if (FREEZE) begin
        ret_en <= 1'b0;
        ls_en  <= 1'b0;
      end else begin
        ret_en <= (n_pop != '0);
        ls_en  <= (n_pop == CNT_W'(2));
        if (n_pop != '0) begin
          ret_reg  <= q_reg[head];
          ret_data <= q_data[head];
        end
        if (n_pop == CNT_W'(2)) begin
          ls_reg_q  <= q_reg[head_p1];
          ls_data_q <= q_data[head_p1];
        end
      end
    end
  end

`ifdef RETQ_FWD_EN
  // Newest-match lookup: later assignments override, so scan oldest first.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (ret_en && (ret_reg == fwd_reg)) begin
      fwd_hit  = 1'b1;
      fwd_data = ret_data;
    end
    if (ls_en && (ls_reg_q == fwd_reg)) begin
      fwd_hit  = 1'b1;
      fwd_data = ls_data_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) && (q_reg[head + PTR_W'(i)] == fwd_reg)) begin
        fwd_hit  = 1'b1;
        fwd_data = q_data[head + PTR_W'(i)];
      end
    end
  end
`endif

endmodule

// File: tb/tb_retire_wb_queue.sv
// Bench for retire_wb_queue: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model of the buffer.
module tb_retire_wb_queue;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [5:0]  r;
    logic [31:0] d;
  } ent_t;

  logic CLK;
  logic RESET;
  logic FREEZE;

  retire_wb_queue_if #(.PTR_W(3), .PREG_W(6)) bus ();

`ifdef RETQ_FWD_EN
  logic [5:0]  fwd_reg;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  retire_wb_queue #(.DEPTH(DEPTH), .PTR_W(3), .PREG_W(6)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .FREEZE   (FREEZE),
    .bus      (bus)
`ifdef RETQ_FWD_EN
    ,
    .fwd_reg  (fwd_reg),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data)
`endif
  );

  int total_checks;
  int passed_checks;

  ent_t mq[$];
  logic e_ret_en;
  logic e_ls_en;
  ent_t e_ret;
  ent_t e_ls;
  logic last_rst;
  logic last_frz;
  logic [31:0] rf [64];

  // Free-running clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got === exp)
      passed_checks++;
    else
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: one clock edge applied to the abstract ordered queue.
  task automatic modelStep();
    int n;
    bit acc;
    last_rst = !RESET;
    last_frz = FREEZE;
    if (!RESET) begin
      mq.delete();
      e_ret_en = 1'b0;
      e_ls_en  = 1'b0;
      e_ret    = '0;
      e_ls     = '0;
      return;
    end
    n   = mq.size();
    acc = (n <= DEPTH - 2);
    if (FREEZE) begin
      e_ret_en = 1'b0;
      e_ls_en  = 1'b0;
    end else begin
      e_ret_en = (n >= 1);
      e_ls_en  = (n >= 2);
      if (n >= 1) e_ret = mq.pop_front();
      if (n >= 2) e_ls  = mq.pop_front();
    end
    if (acc && bus.alu_valid) mq.push_back({bus.alu_reg, bus.alu_data});
    if (acc && bus.ls_valid)  mq.push_back({bus.ls_reg, bus.ls_data});
  endtask

`ifdef RETQ_FWD_EN
  task automatic checkFwd(input logic [5:0] r);
    logic hit;
    logic [31:0] d;
    hit = 1'b0;
    d   = '0;
    for (int i = mq.size() - 1; i >= 0 && !hit; i--) begin
      if (mq[i].r == r) begin
        hit = 1'b1;
        d   = mq[i].d;
      end
    end
    if (!hit && e_ls_en && e_ls.r == r) begin
      hit = 1'b1;
      d   = e_ls.d;
    end
    if (!hit && e_ret_en && e_ret.r == r) begin
      hit = 1'b1;
      d   = e_ret.d;
    end
    fwd_reg = r;
    #1;
    checkOutput("fwd_hit", 32'(fwd_hit), 32'(hit));
    checkOutput("fwd_data", fwd_data, d);
  endtask
`endif

  // Compare all DUT outputs against the model after an edge.
  task automatic verifyOutputs();
    checkOutput("count", 32'(bus.count), 32'(mq.size()));
    checkOutput("in_ready", 32'(bus.in_ready), 32'(mq.size() <= DEPTH - 2));
    checkOutput("ret_en", 32'(bus.do_writeback1_RET), 32'(e_ret_en));
    checkOutput("ls_en", 32'(bus.do_writeback1_LS_RET), 32'(e_ls_en));
    if (e_ret_en || last_rst || last_frz) begin
      checkOutput("ret_reg", 32'(bus.writeRegister1_RET), 32'(e_ret.r));
      checkOutput("ret_data", bus.writeData1_RET, e_ret.d);
    end
    if (e_ls_en || last_rst || last_frz) begin
      checkOutput("ls_reg", 32'(bus.writeRegister1_LS_RET), 32'(e_ls.r));
      checkOutput("ls_data", bus.writeData1_LS_RET, e_ls.d);
    end
    if (bus.do_writeback1_RET)    rf[bus.writeRegister1_RET]    = bus.writeData1_RET;
    if (bus.do_writeback1_LS_RET) rf[bus.writeRegister1_LS_RET] = bus.writeData1_LS_RET;
  endtask

  // Drive one cycle of inputs, advance an edge, then check.
  task automatic applyStimulus(input logic rst_n, input logic frz,
                               input logic av, input logic [5:0] ar, input logic [31:0] ad,
                               input logic lv, input logic [5:0] lr, input logic [31:0] ld);
    RESET         = rst_n;
    FREEZE        = frz;
    bus.alu_valid = av;
    bus.alu_reg   = ar;
    bus.alu_data  = ad;
    bus.ls_valid  = lv;
    bus.ls_reg    = lr;
    bus.ls_data   = ld;
    @(posedge CLK);
    modelStep();
    @(negedge CLK);
    #1;
    verifyOutputs();
  endtask

  task automatic idle(input logic frz);
    applyStimulus(1'b1, frz, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
  endtask

  initial begin
    logic av, lv, frz, rst;
    logic [5:0] ar, lr;
    logic [31:0] ad, ld;
    total_checks  = 0;
    passed_checks = 0;
    last_rst = 1'b0;
    last_frz = 1'b0;
    e_ret_en = 1'b0;
    e_ls_en  = 1'b0;
    e_ret    = '0;
    e_ls     = '0;
    for (int i = 0; i < 64; i++) rf[i] = '0;
`ifdef RETQ_FWD_EN
    fwd_reg = '0;
`endif

    $display("[TB] reset");
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);

    $display("[TB] single ALU push");
    applyStimulus(1'b1, 1'b0, 1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 6'd0, 32'd0);
    idle(1'b0);
    checkOutput("single_ret_data", bus.writeData1_RET, 32'hDEADBEEF);
    idle(1'b0);

    $display("[TB] dual push same register");
    applyStimulus(1'b1, 1'b0, 1'b1, 6'd9, 32'h11, 1'b1, 6'd9, 32'h22);
    idle(1'b0);
    checkOutput("rf9_final", rf[9], 32'h22);

    $display("[TB] freeze fill and refusal");
    for (int i = 0; i < 7; i++)
      applyStimulus(1'b1, 1'b1, (i % 2) == 0, 6'(i + 1), 32'(32'h100 + i),
                    (i % 2) == 1, 6'(i + 1), 32'(32'h100 + i));
    checkOutput("full_count", 32'(bus.count), 32'd7);
    applyStimulus(1'b1, 1'b1, 1'b1, 6'd20, 32'h200, 1'b1, 6'd21, 32'h201);
    applyStimulus(1'b1, 1'b0, 1'b1, 6'd20, 32'h200, 1'b1, 6'd21, 32'h201);
    applyStimulus(1'b1, 1'b0, 1'b1, 6'd20, 32'h200, 1'b1, 6'd21, 32'h201);
    for (int i = 0; i < 4; i++) idle(1'b0);

    $display("[TB] sustained dual pushes");
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, 6'(2 * i), 32'(32'h1000 + 2 * i),
                    1'b1, 6'(2 * i + 1), 32'(32'h1000 + 2 * i + 1));
    for (int i = 0; i < 3; i++) idle(1'b0);

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, 1'b1, 6'(30 + i), 32'(i), 1'b1, 6'(40 + i), 32'(i));
    applyStimulus(1'b1, 1'b0, 1'b1, 6'd50, 32'h50, 1'b0, 6'd0, 32'd0);
    checkOutput("pre_reset_count", 32'(bus.count), 32'd5);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 6'd7, 32'h77, 1'b0, 6'd0, 32'd0);
    idle(1'b0);
    checkOutput("post_reset_ret", bus.writeData1_RET, 32'h77);

`ifdef RETQ_FWD_EN
    $display("[TB] forwarding");
    applyStimulus(1'b1, 1'b1, 1'b1, 6'd12, 32'hA, 1'b0, 6'd0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 6'd12, 32'hB, 1'b0, 6'd0, 32'd0);
    checkFwd(6'd12);
    checkOutput("fwd12_data", fwd_data, 32'hB);
    checkFwd(6'd13);
    idle(1'b0);
    checkFwd(6'd12);
    idle(1'b0);
`endif

    $display("[TB] randomized traffic");
    av = 1'b0; lv = 1'b0; ar = '0; lr = '0; ad = '0; ld = '0;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) != 0);
      frz = ($urandom_range(0, 3) == 0);
      if (mq.size() <= DEPTH - 2 || !(av || lv)) begin
        av = ($urandom_range(0, 2) != 0);
        lv = ($urandom_range(0, 2) != 0);
        ar = 6'($urandom_range(0, 15));
        lr = 6'($urandom_range(0, 15));
        ad = $urandom;
        ld = $urandom;
      end
      applyStimulus(rst, frz, av, ar, ad, lv, lr, ld);
`ifdef RETQ_FWD_EN
      checkFwd(6'($urandom_range(0, 15)));
`endif
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
